sysz_matrix_stream: RTL and testbench
=====================================

Name: sysz_matrix_stream

Overview:
- Host-side I/O sequencer for the Gaussian-elimination systemizer (L×K matrix over GF(M), N elements packed per memory word).
- Streams a full matrix from chip pins into the shared matrix memory, pulses the systemizer start, and waits for completion.
- On success, streams the systemized matrix back out. On failure, reports the failure and skips the unload.
- Sits between the pin-level byte interface and the systemizer/matrix-RAM pair, and owns the RAM port select.

Parameters:
- N, 2, matrix elements packed per memory word
- L, 8, matrix rows
- K, 10, matrix columns
- M, 2, field size; each element is CLOG2(M) bits
- W, N*CLOG2(M), memory word / stream width (derived)
- DEPTH, L*K/N, words per matrix (40 at defaults)
- AW, CLOG2(L*K/N), memory address width (derived)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous reset, active-low
- in_data  in  W  matrix word from host, row-major, word 0 first
- in_valid  in  1  host word valid
- in_ready  out  1  block accepts in_data this cycle
- out_data  out  W  result word to host
- out_valid  out  1  out_data valid
- out_ready  in  1  host accepts out_data
- abort  in  1  abandon current operation, return to LOAD
- mem_sel  out  1  1 = this block drives matrix RAM; 0 = systemizer drives it
- mem_wr_en  out  1  RAM write strobe
- mem_wr_addr  out  AW  RAM write address
- mem_wr_data  out  W  RAM write data
- mem_rd_en  out  1  RAM read strobe
- mem_rd_addr  out  AW  RAM read address
- mem_rd_data  in  W  RAM read data, valid exactly 1 cycle after mem_rd_en
- sys_start  out  1  one-cycle start pulse to systemizer
- sys_done  in  1  systemizer completion pulse
- sys_fail  in  1  systemizer result: matrix singular
- sys_success  in  1  systemizer result: systematic form reached
- status_fail  out  1  sticky: last run failed
- status_success  out  1  sticky: last run succeeded and was fully unloaded

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=LOAD, addr=0.
  - Outputs: in_ready=1, mem_sel=1, status_*=0. All other outputs 0.
- Address counter: AW bits, counts 0..DEPTH-1, never wraps past DEPTH-1.
- LOAD state:
  - in_ready=1, mem_sel=1.
  - On in_valid&in_ready: mem_wr_en=1, mem_wr_addr=addr, mem_wr_data=in_data (same cycle, combinational); addr++.
  - First accepted word (addr=0) clears status_fail and status_success.
  - Word at addr=DEPTH-1 accepted -> addr=0, next state KICK.
- KICK state: mem_sel=0, in_ready=0, sys_start=1 for exactly this cycle -> RUN.
- RUN state:
  - mem_sel=0; all mem strobes 0. Waits for sys_done.
  - sys_done & sys_success & !sys_fail -> UNLOAD_RD.
  - sys_done with sys_fail, or with neither flag set -> status_fail=1, next state LOAD.
  - sys_done & sys_fail & sys_success: fail wins.
- UNLOAD_RD state: mem_sel=1, mem_rd_en=1, mem_rd_addr=addr -> UNLOAD_WAIT.
- UNLOAD_WAIT state: capture mem_rd_data into out_data register -> UNLOAD_OUT.
- UNLOAD_OUT state:
  - out_valid=1; out_data stays stable until out_ready.
  - On out_valid&out_ready: if addr=DEPTH-1 -> status_success=1, addr=0, LOAD; else addr++, UNLOAD_RD.
  - Throughput: one word per 3 cycles minimum. Latency from sys_done to first out_valid is 3 cycles.
- abort:
  - Sampled in every state, higher priority than all other transitions.
  - Next state LOAD, addr=0, out_valid=0, no strobe that cycle; status_* unchanged.
  - abort in RUN does not stop the systemizer. A sys_done arriving later while in LOAD is ignored.
- in_ready is 0 in every state except LOAD. Host words presented then are not consumed.
- sys_done seen outside RUN is ignored.
- Reset mid-operation: same as reset; partial matrix in RAM is not cleared.

Test Plan:
- Load words 0..39 with data=addr[1:0], in_valid held high -> 40 writes on consecutive cycles, addrs 0..39; sys_start pulses once, 1 cycle after the last write.
- Same load, then sys_done+sys_success 5 cycles later, out_ready=1 -> mem_rd_addr 0..39 in order; out_data equals RAM contents; 40 handshakes; status_success=1, back in LOAD.
- Load, then sys_done+sys_fail -> no mem_rd_en, out_valid stays 0; status_fail=1; next accepted word clears status_fail.
- Unload with out_ready toggling 1-of-3 cycles -> out_data stable while out_valid&!out_ready; no word dropped or duplicated; exactly 40 handshakes.
- abort at load word 17, then full 40-word reload -> no sys_start until the 40th word of the new load; writes restart at addr 0.
- rst_n low during UNLOAD_OUT at word 20 -> next cycle out_valid=0, in_ready=1, status_*=0, addr=0.

Source files
------------

// File: rtl/sysz_matrix_stream.sv
// rtl/sysz_matrix_stream.sv - host I/O sequencer: load matrix, kick systemizer, unload result
module sysz_matrix_stream #(
    parameter int N     = 2,
    parameter int L     = 8,
    parameter int K     = 10,
    parameter int M     = 2,
    parameter int W     = N * $clog2(M),
    parameter int DEPTH = L * K / N,
    parameter int AW    = $clog2(L * K / N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [W-1:0]  out_data,
    output logic          out_valid,
    input  logic          out_ready,
    input  logic          abort,
    output logic          mem_sel,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_wr_addr,
    output logic [W-1:0]  mem_wr_data,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_rd_addr,
    input  logic [W-1:0]  mem_rd_data,
    output logic          sys_start,
    input  logic          sys_done,
    input  logic          sys_fail,
    input  logic          sys_success,
    output logic          status_fail,
    output logic          status_success
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_LOAD,
        S_KICK,
        S_RUN,
        S_UNLOAD_RD,
        S_UNLOAD_WAIT,
        S_UNLOAD_OUT
    } state_t;

    state_t        state, next_state;
    logic [AW-1:0] addr, addr_next;
    logic [W-1:0]  out_data_q;
    logic          fail_next, success_next;
    logic          capture;

    // State, address counter, sticky status and the output holding register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_LOAD;
            addr           <= '0;
            out_data_q     <= '0;
            status_fail    <= 1'b0;
            status_success <= 1'b0;
        end else begin
            state          <= next_state;
            addr           <= addr_next;
            status_fail    <= fail_next;
            status_success <= success_next;
            if (capture) begin
                out_data_q <= mem_rd_data;
            end
        end
    end

    // Next-state, counter and strobe decode; abort overrides everything at the end
    always_comb begin
        next_state   = state;
        addr_next    = addr;
        fail_next    = status_fail;
        success_next = status_success;
        capture      = 1'b0;
        in_ready     = 1'b0;
        mem_sel      = 1'b1;
        mem_wr_en    = 1'b0;
        mem_rd_en    = 1'b0;
        sys_start    = 1'b0;
        out_valid    = 1'b0;

        case (state)
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mem_wr_en = 1'b1;
                    // A new matrix starting invalidates the previous run's result
                    if (addr == '0) begin
                        fail_next    = 1'b0;
                        success_next = 1'b0;
                    end
                    if (addr == LAST) begin
                        addr_next  = '0;
                        next_state = S_KICK;
                    end else begin
                        addr_next = addr + AW'(1);
                    end
                end
            end
            S_KICK: begin
                mem_sel    = 1'b0;
                sys_start  = 1'b1;
                next_state = S_RUN;
            end
            S_RUN: begin
                mem_sel = 1'b0;
                if (sys_done) begin
                    // Singular wins over success; no flag at all is also a failure
                    if (sys_success && !sys_fail) begin
                        next_state = S_UNLOAD_RD;
                    end else begin
                        fail_next  = 1'b1;
                        next_state = S_LOAD;
                    end
                end
            end
            S_UNLOAD_RD: begin
                mem_rd_en  = 1'b1;
                next_state = S_UNLOAD_WAIT;
            end
            S_UNLOAD_WAIT: begin
                capture    = 1'b1;
                next_state = S_UNLOAD_OUT;
            end
            S_UNLOAD_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (addr == LAST) begin
                        success_next = 1'b1;
                        addr_next    = '0;
                        next_state   = S_LOAD;
                    end else begin
                        addr_next  = addr + AW'(1);
                        next_state = S_UNLOAD_RD;
                    end
                end
            end
            default: begin
                addr_next  = '0;
                next_state = S_LOAD;
            end
        endcase

        if (abort) begin
            next_state   = S_LOAD;
            addr_next    = '0;
            fail_next    = status_fail;
            success_next = status_success;
            capture      = 1'b0;
            in_ready     = 1'b0;
            mem_wr_en    = 1'b0;
            mem_rd_en    = 1'b0;
            sys_start    = 1'b0;
            out_valid    = 1'b0;
        end
    end

    // Address/data buses idle at zero whenever their strobe is low
    always_comb begin
        mem_wr_addr = mem_wr_en ? addr : '0;
        mem_wr_data = mem_wr_en ? in_data : '0;
        mem_rd_addr = mem_rd_en ? addr : '0;
        out_data    = out_data_q;
    end

endmodule

// File: tb/tb_sysz_matrix_stream.sv
// tb/tb_sysz_matrix_stream.sv - self-checking bench for sysz_matrix_stream
module tb_sysz_matrix_stream;

    localparam int W     = 2;
    localparam int AW    = 6;
    localparam int DEPTH = 40;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic          abort;
    logic          mem_sel;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [W-1:0]  mem_wr_data;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [W-1:0]  mem_rd_data;
    logic          sys_start;
    logic          sys_done;
    logic          sys_fail;
    logic          sys_success;
    logic          status_fail;
    logic          status_success;

    logic [W-1:0]  ram [DEPTH];
    logic          sys_wr_en   = 1'b0;
    logic [AW-1:0] sys_wr_addr = '0;
    logic [W-1:0]  sys_wr_data = '0;

    int exp_mat [DEPTH];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sysz_matrix_stream dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .abort(abort), .mem_sel(mem_sel),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .sys_start(sys_start), .sys_done(sys_done), .sys_fail(sys_fail),
        .sys_success(sys_success),
        .status_fail(status_fail), .status_success(status_success)
    );

    // Shared matrix RAM: host side when mem_sel=1, stand-in systemizer otherwise
    always @(posedge clk) begin
        if (mem_sel && mem_wr_en) ram[mem_wr_addr] <= mem_wr_data;
        if (!mem_sel && sys_wr_en) ram[sys_wr_addr] <= sys_wr_data;
        if (mem_sel && mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_matrix(input int abort_at, input bit rnd);
        for (int i = 0; i < DEPTH; i++) begin
            logic [W-1:0] d;
            d = rnd ? W'($urandom) : W'(i);
            cyc();
            in_valid = 1'b1;
            in_data  = d;
            abort    = (i == abort_at);
            #1;
            if (i == abort_at) begin
                chk("abort_wr_en", 32'(mem_wr_en), 0);
                cyc();
                abort    = 1'b0;
                in_valid = 1'b0;
                #1;
                chk("abort_back_load", 32'(in_ready), 1);
                return;
            end
            chk("load_in_ready", 32'(in_ready), 1);
            chk("load_wr_en", 32'(mem_wr_en), 1);
            chk("load_wr_addr", 32'(mem_wr_addr), i);
            chk("load_wr_data", 32'(mem_wr_data), 32'(d));
            chk("load_no_start", 32'(sys_start), 0);
            chk("load_mem_sel", 32'(mem_sel), 1);
            if (i == 1) begin
                chk("load_clr_fail", 32'(status_fail), 0);
                chk("load_clr_success", 32'(status_success), 0);
            end
            exp_mat[i] = int'(d);
        end
        cyc();
        in_data = W'($urandom);
        #1;
        chk("kick_start", 32'(sys_start), 1);
        chk("kick_mem_sel", 32'(mem_sel), 0);
        chk("kick_in_ready", 32'(in_ready), 0);
        chk("kick_wr_en", 32'(mem_wr_en), 0);
        in_valid = 1'b0;
    endtask

    // flags: 0 success, 1 fail, 2 neither flag, 3 both flags
    task automatic run_sys(input int delay, input int flags);
        for (int i = 0; i < delay; i++) begin
            cyc();
            sys_wr_en   = 1'b1;
            sys_wr_addr = AW'($urandom_range(0, DEPTH - 1));
            sys_wr_data = W'($urandom);
            exp_mat[sys_wr_addr] = int'(sys_wr_data);
            #1;
            chk("run_mem_sel", 32'(mem_sel), 0);
            chk("run_strobes", {29'd0, mem_wr_en, mem_rd_en, sys_start}, 0);
            chk("run_in_ready", 32'(in_ready), 0);
        end
        cyc();
        sys_wr_en   = 1'b0;
        sys_done    = 1'b1;
        sys_success = (flags == 0) || (flags == 3);
        sys_fail    = (flags == 1) || (flags == 3);
        cyc();
        sys_done    = 1'b0;
        sys_success = 1'b0;
        sys_fail    = 1'b0;
        #1;
        if (flags == 0) begin
            chk("ok_rd_en", 32'(mem_rd_en), 1);
            chk("ok_rd_addr", 32'(mem_rd_addr), 0);
            chk("ok_mem_sel", 32'(mem_sel), 1);
        end else begin
            chk("bad_in_ready", 32'(in_ready), 1);
            chk("bad_status_fail", 32'(status_fail), 1);
            chk("bad_status_success", 32'(status_success), 0);
            chk("bad_rd_en", 32'(mem_rd_en), 0);
        end
    endtask

    // mode: 0 ready always, 1 ready one cycle in three, 2 random ready
    task automatic unload(input int mode, input int stop_at);
        int hs = 0;
        int n = 0;
        int rd_idx = 1;
        bit held = 1'b0;
        logic [W-1:0] held_data = '0;
        while (hs < DEPTH && n < 1000) begin
            cyc();
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (n % 3 == 2);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (n == 0) chk("first_valid_low", 32'(out_valid), 0);
            if (n == 1) chk("first_valid_high", 32'(out_valid), 1);
            if (mem_rd_en) begin
                chk("unload_rd_addr", 32'(mem_rd_addr), rd_idx);
                rd_idx++;
            end
            if (held) chk("unload_stable", 32'(out_data), 32'(held_data));
            held = 1'b0;
            if (out_valid) begin
                chk("unload_data", 32'(out_data), exp_mat[hs]);
                if (hs == stop_at) begin
                    rst_n     = 1'b0;
                    out_ready = 1'b0;
                    cyc();
                    rst_n = 1'b1;
                    chk("rst_out_valid", 32'(out_valid), 0);
                    chk("rst_in_ready", 32'(in_ready), 1);
                    chk("rst_status", {30'd0, status_fail, status_success}, 0);
                    chk("rst_rd_en", 32'(mem_rd_en), 0);
                    return;
                end
                if (out_ready) hs++;
                else begin
                    held      = 1'b1;
                    held_data = out_data;
                end
            end
            n++;
        end
        chk("unload_handshakes", hs, DEPTH);
        chk("unload_reads", rd_idx, DEPTH);
        cyc();
        out_ready = 1'b0;
        #1;
        chk("done_in_ready", 32'(in_ready), 1);
        chk("done_status_success", 32'(status_success), 1);
        chk("done_out_valid", 32'(out_valid), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b0; abort = 1'b0;
        sys_done = 1'b0; sys_fail = 1'b0; sys_success = 1'b0;
        cyc();
        cyc();
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_mem_sel", 32'(mem_sel), 1);
        chk("rst_status", {30'd0, status_fail, status_success}, 0);
        chk("rst_strobes", {28'd0, mem_wr_en, mem_rd_en, sys_start, out_valid}, 0);
        chk("rst_out_data", 32'(out_data), 0);
        rst_n = 1'b1;

        // Plain load with addr-pattern data, success, full-rate unload
        load_matrix(-1, 1'b0);
        run_sys(4, 0);
        unload(0, -1);

        // Singular result: no unload, stray sys_done in LOAD ignored
        load_matrix(-1, 1'b1);
        run_sys(2, 1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            sys_done    = (i == 2);
            sys_success = (i == 2);
            #1;
            chk("fail_idle_rd_en", 32'(mem_rd_en), 0);
            chk("fail_idle_out_valid", 32'(out_valid), 0);
            chk("fail_idle_in_ready", 32'(in_ready), 1);
        end
        sys_done = 1'b0; sys_success = 1'b0;

        // Neither flag, then both flags: each counts as a failure
        load_matrix(-1, 1'b1);
        run_sys(3, 2);
        load_matrix(-1, 1'b1);
        run_sys(1, 3);

        // Success with a slow host
        load_matrix(-1, 1'b1);
        run_sys(5, 0);
        unload(1, -1);

        // Abort mid-load, then a full reload from address 0
        load_matrix(17, 1'b1);
        load_matrix(-1, 1'b1);
        run_sys(3, 0);
        unload(2, -1);

        // Abort while the systemizer runs; its late completion is ignored
        load_matrix(-1, 1'b1);
        cyc();
        abort = 1'b1;
        #1;
        chk("run_abort_start", 32'(sys_start), 0);
        cyc();
        abort = 1'b0;
        #1;
        chk("run_abort_load", 32'(in_ready), 1);
        cyc();
        sys_done = 1'b1; sys_success = 1'b1;
        cyc();
        sys_done = 1'b0; sys_success = 1'b0;
        #1;
        chk("late_done_rd_en", 32'(mem_rd_en), 0);
        chk("late_done_in_ready", 32'(in_ready), 1);
        chk("late_done_status", {30'd0, status_fail, status_success}, 0);

        // Reset in the middle of unloading word 20, then a clean run
        load_matrix(-1, 1'b1);
        run_sys(2, 0);
        unload(2, 20);
        load_matrix(-1, 1'b0);
        run_sys(0, 0);
        unload(0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
